// File: rtl/nn_pkg.sv
// nn_pkg: shared neuron types, accumulator sizing and requantisation.
package nn_pkg;
  typedef enum logic {IDLE, ACCUM} mac_state_t;
  localparam int MAX_W = 128;
  function automatic int acc_w(input int q_size, input int input_size);
    return 2 * q_size + $clog2(input_size) + 1;
  endfunction
  // Round half-up, saturate to q_size bits, optional ReLU; result sits in the low q_size bits.
  function automatic logic signed [MAX_W-1:0] requant(input logic signed [MAX_W-1:0] s,
                                                      input int q_size, input int frac_bits,
                                                      input logic relu);
    logic signed [MAX_W-1:0] one, hi, lo, r;
    one = MAX_W'(1);
    hi = (one <<< (q_size - 1)) - one;
    lo = -hi - one;
    r = (s + (one <<< (frac_bits - 1))) >>> frac_bits;
    r = r > hi ? hi : r < lo ? lo : r;
    return relu && r[MAX_W-1] ? '0 : r;
  endfunction
endpackage

// File: rtl/mac_requant.sv
// mac_requant: combinational requantisation of the accumulator sum to one output word.
module mac_requant import nn_pkg::*; #(
  parameter int Q_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W = 35
) (
  input  logic [ACC_W-1:0]  sum,
  input  logic              relu_en,
  output logic [Q_SIZE-1:0] result
);
  assign result = Q_SIZE'(requant(MAX_W'($signed(sum)), Q_SIZE, FRAC_BITS, relu_en));
endmodule

// File: rtl/serial_mac.sv
// serial_mac: serial multiply-accumulate neuron, one requantised result per INPUT_SIZE-element vector.
module serial_mac import nn_pkg::*; #(
  parameter int INPUT_SIZE = 8,
  parameter int Q_SIZE = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [Q_SIZE-1:0]             serial_in,
  output logic [$clog2(INPUT_SIZE)-1:0] weight_addr,
  input  logic [Q_SIZE-1:0]             weight_in,
  input  logic [Q_SIZE-1:0]             bias_in,
  input  logic                          relu_en,
  output logic [Q_SIZE-1:0]             result,
  output logic                          result_valid,
  output logic                          busy,
  output logic                          overrun
);
  localparam int ACC_W = acc_w(Q_SIZE, INPUT_SIZE);
  localparam int CW = $clog2(INPUT_SIZE);
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);
  mac_state_t state;
  logic [CW-1:0] cnt;
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [2*Q_SIZE-1:0] prod;
  logic relu, last, accept;
  logic [Q_SIZE-1:0] rq;
  always_comb begin
    prod = (2*Q_SIZE)'($signed(serial_in)) * (2*Q_SIZE)'($signed(weight_in));
    sum = acc + ACC_W'(prod);
    last = state == ACCUM && cnt == LAST;
    accept = start && (state == IDLE || last);
  end
  assign weight_addr = cnt;
  assign busy = state == ACCUM;
  mac_requant #(.Q_SIZE(Q_SIZE), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_requant (
    .sum(sum),
    .relu_en(relu),
    .result(rq)
  );
  // A start in the last element cycle reloads acc while the finished sum is requantised.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      relu <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      result_valid <= last;
      if (last) result <= rq;
      if (start && !accept) overrun <= 1'b1;
      if (accept) begin
        state <= ACCUM;
        cnt <= '0;
        acc <= ACC_W'($signed(bias_in)) <<< FRAC_BITS;
        relu <= relu_en;
      end else if (state == ACCUM) begin
        state <= last ? IDLE : ACCUM;
        cnt <= last ? '0 : cnt + CW'(1);
        acc <= sum;
      end
    end
endmodule

// File: tb/tb_serial_mac.sv
// tb_serial_mac: scoreboard bench for serial_mac at INPUT_SIZE=4, Q_SIZE=16, FRAC_BITS=8.
module tb_serial_mac;
  typedef logic [15:0] vec_t [4];
  typedef struct {logic [15:0] val; int cyc;} exp_t;
  logic clk = 0, rst_n = 1, start = 0, relu_en = 0;
  logic [15:0] serial_in = 0, weight_in = 0, bias_in = 0, result;
  logic [1:0] weight_addr;
  logic result_valid, busy, overrun;
  int cyc = 0, checks = 0, failures = 0;
  exp_t sbq[$];
  exp_t e;
  vec_t na = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
  vec_t nw = '{16'h0080, 16'h0080, 16'h0100, 16'h0200};
  vec_t mx = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
  vec_t ng = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
  vec_t one = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
  vec_t r1 = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
  vec_t r2 = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
  vec_t rw = '{16'h0080, 16'h0000, 16'h0000, 16'h0000};
  vec_t ba = '{16'h0300, 16'hFE00, 16'h0100, 16'h0040};
  vec_t bw = '{16'h0100, 16'h0080, 16'hFF80, 16'h0400};

  serial_mac #(.INPUT_SIZE(4), .Q_SIZE(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .serial_in(serial_in),
    .weight_addr(weight_addr), .weight_in(weight_in), .bias_in(bias_in),
    .relu_en(relu_en), .result(result), .result_valid(result_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model(vec_t a, vec_t w, logic [15:0] b, logic r);
    longint s;
    s = longint'($signed(b)) * 256;
    for (int k = 0; k < 4; k++) s += longint'($signed(a[k])) * longint'($signed(w[k]));
    s = (s + 128) >>> 8;
    s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
    if (r && s < 0) s = 0;
    return s[15:0];
  endfunction

  // Caller is already at the negedge of the start cycle; returns in the last element cycle.
  task automatic run(input vec_t a, input vec_t w, input logic [15:0] b, input logic r, input int xk);
    start = 1;
    bias_in = b;
    relu_en = r;
    sbq.push_back('{model(a, w, b, r), cyc + 5});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = k == xk;
      bias_in = 16'h5A5A;
      relu_en = ~r;
      serial_in = a[k];
      weight_in = w[k];
      chk("weight_addr", weight_addr, k);
      chk("busy_high", busy, 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 0;
      serial_in = 16'($urandom);
      weight_in = 16'($urandom);
      chk("busy_low", busy, 0);
    end
  endtask

  always @(negedge clk)
    if (result_valid) begin
      if (sbq.size() == 0) chk("spurious_valid", result_valid, 0);
      else begin
        e = sbq.pop_front();
        chk("result", result, e.val);
        chk("latency", cyc, e.cyc);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", weight_addr, 0);
    rst_n = 1;
    @(negedge clk); run(na, nw, 16'h0040, 0, -1); idle(2);
    @(negedge clk); run(mx, mx, 16'h0000, 0, -1); idle(2);
    @(negedge clk); run(ng, one, 16'h0000, 0, -1); idle(2);
    @(negedge clk); run(ng, one, 16'h0000, 1, -1); idle(2);
    @(negedge clk); run(r1, rw, 16'h0000, 0, -1); idle(2);
    @(negedge clk); run(r2, rw, 16'h0000, 1, -1); idle(2);
    @(negedge clk); run(na, nw, 16'h0040, 0, -1); run(ba, bw, 16'hFFC0, 0, -1); idle(2);
    chk("overrun_clear", overrun, 0);
    @(negedge clk); run(na, nw, 16'h0040, 0, 1);
    chk("overrun_set", overrun, 1);
    idle(3);
    chk("overrun_sticky", overrun, 1);
    @(negedge clk);
    start = 1;
    bias_in = 16'h0040;
    sbq.push_back('{model(na, nw, 16'h0040, 0), cyc + 5});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 0;
      serial_in = na[k];
      weight_in = nw[k];
    end
    @(negedge clk);
    rst_n = 0;
    sbq.delete();
    #1;
    chk("arst_result", result, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_addr", weight_addr, 0);
    #3 rst_n = 1;
    idle(10);
    chk("drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_mac.md
# serial_mac

Serial multiply-accumulate neuron that sits directly downstream of the vector serializer. It consumes one signed fixed-point activation per cycle from the serializer's `serial_out` and multiplies it by the matching weight. It accumulates INPUT_SIZE products on top of a bias, then requantises the sum (round, saturate, optional ReLU) to one Q_SIZE output word. Each start pulse produces one result, and a new start can be accepted every INPUT_SIZE cycles.

## Interface
- `INPUT_SIZE`, 8: elements per vector; must be ≥ 2.
- `Q_SIZE`, 16: word width of activations, weights, bias and result (signed two's complement).
- `FRAC_BITS`, 8: fractional bits of every Q_SIZE word; must satisfy 1 ≤ FRAC_BITS < Q_SIZE.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: asserted in the same cycle as the upstream `serializer_update`.
- `serial_in` in Q_SIZE: activation stream, driven by serializer `serial_out`.
- `weight_addr` out $clog2(INPUT_SIZE): index of the element currently on `serial_in`.
- `weight_in` in Q_SIZE: weight at `weight_addr`, combinational lookup, valid in the same cycle.
- `bias_in` in Q_SIZE: bias, sampled only in the cycle `start` is accepted.
- `relu_en` in 1: sampled together with `bias_in`.
- `result` out Q_SIZE: requantised output, held until the next result.
- `result_valid` out 1: one-cycle pulse, high when `result` updates.
- `busy` out 1: high in state ACCUM.
- `overrun` out 1: sticky flag for a rejected start; cleared only by reset.

## Operation
- States: IDLE, ACCUM. Counter `cnt` runs 0..INPUT_SIZE-1; `weight_addr = cnt`.
- **Start acceptance:** `start` is accepted in IDLE, or in ACCUM when `cnt == INPUT_SIZE-1`.
  - On acceptance: go to (or stay in) ACCUM, `cnt` ← 0.
  - `acc` ← sign-extended `bias_in` << FRAC_BITS; latch `relu_en`.
- **Rejected start:** `start` in ACCUM with `cnt < INPUT_SIZE-1` is ignored and sets `overrun` ← 1. The accumulation in progress is unaffected.
- **ACCUM cycle:** `acc` ← `acc` + `serial_in`·`weight_in` (full 2·Q_SIZE signed product); `cnt` ← `cnt` + 1.
- **Accumulator width:** ACC_W = 2·Q_SIZE + $clog2(INPUT_SIZE) + 1. No internal overflow is possible.
- **Last element (`cnt == INPUT_SIZE-1`):**
  - Final sum s = `acc` + product.
  - `result` ← requant(s); `result_valid` ← 1 for exactly one cycle.
  - Next state is IDLE unless `start` is accepted in that cycle.
- **requant(s):**
  - Round half-up: r = (s + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift).
  - Saturate to [−2^(Q_SIZE−1), 2^(Q_SIZE−1)−1].
  - If the latched `relu_en` is set and the value is negative, output 0.
- **Reset values:** state IDLE, `cnt` 0, `acc` 0, `result` 0, `result_valid` 0, `busy` 0, `overrun` 0, `weight_addr` 0.
- **Reset mid-operation:** the partial sum is discarded and no `result_valid` follows.
- `serial_in` and `weight_in` are don't-care in IDLE.

## Timing
- **Latency:**
  - `start` at cycle T.
  - Elements k = 0..INPUT_SIZE-1 consumed at cycles T+1+k.
  - `result_valid` high at T+INPUT_SIZE+1.
- **Throughput:** one vector per INPUT_SIZE cycles. A start at T+INPUT_SIZE gives gap-free back-to-back operation.
- **Busy window:** `busy` is high T+1..T+INPUT_SIZE. It stays high continuously under back-to-back operation.
- **Start in the last ACCUM cycle:** the result pulse and the new accumulation's first element occur in the same cycle without interaction.

## Structure
- Shared package `nn_pkg`:
  - `mac_state_t` enum (IDLE, ACCUM).
  - ACC_W computation function.
  - `requant` function (round, saturate, ReLU), reusable by other neuron stages.
- One natural sub-module: `mac_requant`, combinational. It takes ACC_W sum and `relu_en` and outputs the Q_SIZE result.
- Everything else (FSM, counter, accumulator, flags) lives in `serial_mac`.

## Test plan
All scenarios use INPUT_SIZE=4, Q_SIZE=16, FRAC_BITS=8.
- **Nominal:** activations {0x0100, 0x0200, 0xFF00, 0x0080}, weights {0x0080, 0x0080, 0x0100, 0x0200}, bias 0x0040, `start` at T → `result_valid` only at T+5, `result` = 0x01C0.
- **Saturation and ReLU:**
  - All activations and weights 0x7FFF → `result` 0x7FFF.
  - Activations all 0xFF00, weights all 0x0100, bias 0: `relu_en`=0 → 0xFC00; `relu_en`=1 → 0x0000.
- **Rounding:** single nonzero product 0x0001·0x0080 → 0x0001. Product 0xFFFF·0x0080 → 0x0000.
- **Back-to-back:** starts at T and T+4 with different vectors → pulses at T+5 and T+9, both results correct, `busy` continuous from T+1 to T+8.
- **Overrun:** extra `start` at T+2 → `overrun` goes 1 and stays 1; result at T+5 is unchanged from the nominal value.
- **Async reset:** `rst_n` low at T+3 for half a cycle → all outputs return to reset values immediately, and no `result_valid` occurs afterwards.
